// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA constants and colour codes for the pixel renderer.
//   Display geometry (H_ACTIVE/V_ACTIVE) and rgb332 colour constants {R3,G3,B2}.
package vga_pkg;
  typedef logic [7:0] rgb332_t;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam rgb332_t COL_BLACK   = 8'h00;
  localparam rgb332_t COL_WHITE   = 8'hFF;
  localparam rgb332_t COL_PLAYER  = 8'h1C;
  localparam rgb332_t COL_ALIEN_A = 8'hE3;
  localparam rgb332_t COL_ALIEN_B = 8'h1F;
  localparam rgb332_t COL_DEBUG   = 8'hE0;
endpackage

// File: rtl/pixel_renderer_if.sv
// pixel_renderer_if: timing-generator/game-state inputs and DAC-side outputs of the pixel renderer.
//   master: drives enable, hPos/vPos, sync inputs and game state; receives frameDone, hSync, vSync, rgb.
//   slave : the renderer side.
interface pixel_renderer_if #(parameter int N_ALIENS = 32);
  import vga_pkg::*;
  logic                enable;
  logic [9:0]          hPos, vPos;
  logic                hSyncIn, vSyncIn;
  logic [9:0]          playerX, gridX, gridY;
  logic [N_ALIENS-1:0] aliveMask;
  logic [9:0]          shotX, shotY;
  logic                shotValid;
  logic                frameDone, hSync, vSync;
  rgb332_t             rgb;
  modport master (
    output enable, hPos, vPos, hSyncIn, vSyncIn, playerX, gridX, gridY, aliveMask, shotX, shotY, shotValid,
    input  frameDone, hSync, vSync, rgb
  );
  modport slave (
    input  enable, hPos, vPos, hSyncIn, vSyncIn, playerX, gridX, gridY, aliveMask, shotX, shotY, shotValid,
    output frameDone, hSync, vSync, rgb
  );
endinterface

// File: rtl/pixel_renderer_sprite_rom.sv
// sprite_rom: 32x16-bit alien bitmap ROM, one-clock registered read, advanced only on i_en.
//   clk, reset (async active-low), i_en (pixel tick), i_addr {shape, row}, o_data row bits (bit n = sprite column n).
//   Addresses 0..15 hold shape A (top alien row), 16..31 shape B (other rows).
module sprite_rom (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [4:0]  i_addr,
  output logic [15:0] o_data
);
  logic [15:0] w_row;
  logic [15:0] r_data;
  always_comb begin
    w_row = 16'h0000;
    case (i_addr)
      5'd0:  w_row = 16'h0FF0;
      5'd1:  w_row = 16'h3FFC;
      5'd2:  w_row = 16'h7FFE;
      5'd3:  w_row = 16'hFFFF;
      5'd4:  w_row = 16'hE7E7;
      5'd5:  w_row = 16'hE7E7;
      5'd6:  w_row = 16'hFFFF;
      5'd7:  w_row = 16'hFFFF;
      5'd8:  w_row = 16'h3C3C;
      5'd9:  w_row = 16'h6666;
      5'd10: w_row = 16'hC3C3;
      5'd11: w_row = 16'h8181;
      5'd16: w_row = 16'h0180;
      5'd17: w_row = 16'h03C0;
      5'd18: w_row = 16'h07E0;
      5'd19: w_row = 16'h0DB0;
      5'd20: w_row = 16'h1FF8;
      5'd21: w_row = 16'h1FF8;
      5'd22: w_row = 16'h0660;
      5'd23: w_row = 16'h0C30;
      5'd24: w_row = 16'h1818;
      5'd25: w_row = 16'h300C;
      default: w_row = 16'h0000;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_data <= '0;
    else if (i_en) r_data <= w_row;
  assign o_data = r_data;
endmodule

// File: rtl/pixel_renderer.sv
// pixel_renderer: colours each pixel from a per-frame game-state snapshot (alien grid, cannon, shot).
//   clk, reset (async active-low); bus (slave): enable tick, hPos/vPos, hSyncIn/vSyncIn, game state in;
//   frameDone pulse, re-aligned hSync/vSync and rgb332 out. 3-stage pipeline advanced by enable.
//   Optional DEBUG_GRID_EN: outlines grid cells (cellX==0 or cellY==0) in COL_DEBUG.
module pixel_renderer
  import vga_pkg::*;
#(
  parameter int ALIEN_COLS = 8,
  parameter int ALIEN_ROWS = 4,
  parameter int CELL_W     = 32,
  parameter int PLAYER_Y   = 440
) (
  input logic             clk,
  input logic             reset,
  pixel_renderer_if.slave bus
);
  localparam int N  = ALIEN_COLS * ALIEN_ROWS;
  localparam int CS = $clog2(CELL_W);
  localparam int CW = $clog2(ALIEN_COLS);
  localparam int RW = $clog2(ALIEN_ROWS);
  logic [9:0]   r_player_x, r_grid_x, r_grid_y, r_shot_x, r_shot_y;
  logic [N-1:0] r_alive;
  logic         r_shot_v, r_snap_ok, r_frame_done;
  logic [2:0]   r_hs, r_vs;
  logic         w_snap, w_active, w_in_grid, w_player, w_shot, w_px, w_dbg;
  logic signed [10:0] w_rel_x, w_rel_y;
  logic [15:0]  w_rom;
  logic [$clog2(N)-1:0] w_idx;
  rgb332_t      w_rgb, r_rgb;
  logic         r1_active, r1_in_grid, r1_player, r1_shot;
  logic [CW-1:0] r1_col;
  logic [RW-1:0] r1_row;
  logic [CS-1:1] r1_cell_x, r1_cell_y;
  logic         r2_active, r2_alien, r2_row0, r2_player, r2_shot;
  logic [CS-1:1] r2_bit;
  assign w_snap    = bus.enable && bus.hPos == 10'd0 && bus.vPos == 10'(V_ACTIVE);
  assign w_active  = bus.hPos < 10'(H_ACTIVE) && bus.vPos < 10'(V_ACTIVE);
  // Zero-extended subtraction: a pixel left of / above the grid goes negative rather than wrapping.
  assign w_rel_x   = $signed({1'b0, bus.hPos}) - $signed({1'b0, r_grid_x});
  assign w_rel_y   = $signed({1'b0, bus.vPos}) - $signed({1'b0, r_grid_y});
  assign w_in_grid = !w_rel_x[10] && w_rel_x[9:0] < 10'(ALIEN_COLS * CELL_W) &&
                     !w_rel_y[10] && w_rel_y[9:0] < 10'(ALIEN_ROWS * CELL_W);
  // The cannon only appears once a real snapshot exists, so after reset the screen stays background.
  assign w_player  = r_snap_ok && bus.hPos >= r_player_x && {1'b0, bus.hPos} < {1'b0, r_player_x} + 11'd32 &&
                     bus.vPos >= 10'(PLAYER_Y) && bus.vPos < 10'(PLAYER_Y + 16);
  assign w_shot    = r_shot_v && bus.hPos >= r_shot_x && {1'b0, bus.hPos} < {1'b0, r_shot_x} + 11'd2 &&
                     bus.vPos >= r_shot_y && {1'b0, bus.vPos} < {1'b0, r_shot_y} + 11'd8;
  assign w_idx     = $clog2(N)'(int'(r1_row) * ALIEN_COLS + int'(r1_col));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_player_x   <= '0;
      r_grid_x     <= '0;
      r_grid_y     <= '0;
      r_shot_x     <= '0;
      r_shot_y     <= '0;
      r_alive      <= '0;
      r_shot_v     <= 1'b0;
      r_snap_ok    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_snap;
      if (w_snap) begin
        r_player_x <= bus.playerX;
        r_grid_x   <= bus.gridX;
        r_grid_y   <= bus.gridY;
        r_shot_x   <= bus.shotX;
        r_shot_y   <= bus.shotY;
        r_alive    <= bus.aliveMask;
        r_shot_v   <= bus.shotValid;
        r_snap_ok  <= 1'b1;
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_hs       <= '1;
      r_vs       <= '1;
      r1_active  <= 1'b0;
      r1_in_grid <= 1'b0;
      r1_player  <= 1'b0;
      r1_shot    <= 1'b0;
      r1_col     <= '0;
      r1_row     <= '0;
      r1_cell_x  <= '0;
      r1_cell_y  <= '0;
      r2_active  <= 1'b0;
      r2_alien   <= 1'b0;
      r2_row0    <= 1'b0;
      r2_player  <= 1'b0;
      r2_shot    <= 1'b0;
      r2_bit     <= '0;
      r_rgb      <= COL_BLACK;
    end else if (bus.enable) begin
      r_hs       <= {r_hs[1:0], bus.hSyncIn};
      r_vs       <= {r_vs[1:0], bus.vSyncIn};
      r1_active  <= w_active;
      r1_in_grid <= w_in_grid;
      r1_player  <= w_player;
      r1_shot    <= w_shot;
      r1_col     <= w_rel_x[CS+CW-1:CS];
      r1_row     <= w_rel_y[CS+RW-1:CS];
      r1_cell_x  <= w_rel_x[CS-1:1];
      r1_cell_y  <= w_rel_y[CS-1:1];
      r2_active  <= r1_active;
      r2_alien   <= r1_in_grid && r_alive[w_idx];
      r2_row0    <= r1_row == '0;
      r2_player  <= r1_player;
      r2_shot    <= r1_shot;
      r2_bit     <= r1_cell_x;
      r_rgb      <= w_rgb;
    end
`ifdef DEBUG_GRID_EN
  logic r1_dbg, r2_dbg;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r1_dbg <= 1'b0;
      r2_dbg <= 1'b0;
    end else if (bus.enable) begin
      r1_dbg <= w_in_grid && (w_rel_x[CS-1:0] == '0 || w_rel_y[CS-1:0] == '0);
      r2_dbg <= r1_dbg;
    end
  assign w_dbg = r2_dbg;
`else
  assign w_dbg = 1'b0;
`endif
  // Sprites are 16x16 scaled x2, so the ROM row/bit are the cell offsets with the LSB dropped.
  sprite_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .i_en  (bus.enable),
    .i_addr({r1_row != '0, r1_cell_y}),
    .o_data(w_rom)
  );
  assign w_px  = w_rom[r2_bit];
  assign w_rgb = !r2_active         ? COL_BLACK  :
                 r2_shot            ? COL_WHITE  :
                 r2_player          ? COL_PLAYER :
                 w_dbg              ? COL_DEBUG  :
                 (r2_alien && w_px) ? (r2_row0 ? COL_ALIEN_A : COL_ALIEN_B) : COL_BLACK;
  assign bus.frameDone = r_frame_done;
  assign bus.hSync     = r_hs[2];
  assign bus.vSync     = r_vs[2];
  assign bus.rgb       = r_rgb;
endmodule

// File: tb/tb_pixel_renderer.sv
// tb_pixel_renderer: directed pixel vectors plus reset, sync-latency, snapshot and clipping sequences.
module tb_pixel_renderer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pixel_renderer_if bus ();
  pixel_renderer dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];
  function automatic logic [7:0] dbg(input logic [7:0] e);
`ifdef DEBUG_GRID_EN
    return 8'hE0;
`else
    return e;
`endif
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic tick(input logic [9:0] h, input logic [9:0] v);
    bus.hPos = h;
    bus.vPos = v;
    bus.enable = 1'b1;
    @(posedge clk);
    #1 bus.enable = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Pixel presented on one tick, flushed by two off-screen ticks; its colour is then on rgb.
  task automatic render(input logic [9:0] h, input logic [9:0] v, output logic [7:0] px);
    tick(h, v);
    tick(10'd700, 10'd0);
    tick(10'd700, 10'd0);
    px = bus.rgb;
  endtask
  task automatic pix(input string name, input logic [9:0] h, input logic [9:0] v, input logic [7:0] exp);
    logic [7:0] px;
    render(h, v, px);
    chk($sformatf("%s(%0d,%0d)", name, h, v), {8'h0, px}, {8'h0, exp});
  endtask
  task automatic snapshot(input string name);
    tick(10'd0, 10'd480);
    chk({name, "_frameDone"}, {15'h0, bus.frameDone}, 16'h1);
    idle(1);
    chk({name, "_frameDone_drop"}, {15'h0, bus.frameDone}, 16'h0);
  endtask
  task automatic set_game(input logic [9:0] px, gx, gy, input logic [31:0] mask,
                          input logic [9:0] sx, sy, input logic sv);
    bus.playerX = px;
    bus.gridX = gx;
    bus.gridY = gy;
    bus.aliveMask = mask;
    bus.shotX = sx;
    bus.shotY = sy;
    bus.shotValid = sv;
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.hPos = 10'd700;
    bus.vPos = 10'd0;
    bus.hSyncIn = 1'b1;
    bus.vSyncIn = 1'b1;
    set_game(10'd300, 10'd100, 10'd50, 32'hFFFF_FFFF, 10'd110, 10'd55, 1'b1);
    vecs = '{
      '{10'd99,  10'd50,  8'h00},      '{10'd100, 10'd50,  dbg(8'h00)},
      '{10'd108, 10'd50,  dbg(8'hE3)}, '{10'd108, 10'd52,  8'hE3},
      '{10'd100, 10'd56,  dbg(8'hE3)}, '{10'd102, 10'd58,  8'hE3},
      '{10'd106, 10'd58,  8'h00},      '{10'd131, 10'd81,  8'h00},
      '{10'd132, 10'd50,  dbg(8'h00)}, '{10'd116, 10'd90,  8'h1F},
      '{10'd116, 10'd146, dbg(8'h1F)}, '{10'd355, 10'd50,  dbg(8'h00)},
      '{10'd356, 10'd50,  8'h00},      '{10'd108, 10'd178, 8'h00},
      '{10'd110, 10'd55,  8'hFF},      '{10'd111, 10'd62,  8'hFF},
      '{10'd112, 10'd55,  8'hE3},      '{10'd300, 10'd440, 8'h1C},
      '{10'd331, 10'd455, 8'h1C},      '{10'd332, 10'd440, 8'h00},
      '{10'd299, 10'd440, 8'h00},      '{10'd300, 10'd456, 8'h00},
      '{10'd640, 10'd100, 8'h00},      '{10'd700, 10'd300, 8'h00}
    };
    idle(3);
    chk("rst_rgb", {8'h0, bus.rgb}, 16'h0);
    chk("rst_hSync", {15'h0, bus.hSync}, 16'h1);
    chk("rst_vSync", {15'h0, bus.vSync}, 16'h1);
    chk("rst_frameDone", {15'h0, bus.frameDone}, 16'h0);
    reset = 1'b1;
    idle(1);
    pix("pre_snap_black", 10'd108, 10'd52, 8'h00);
    snapshot("snap0");
    foreach (vecs[i]) pix($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].exp);
    // Game state changing mid-frame must not reach the screen before the next snapshot.
    bus.aliveMask[0] = 1'b0;
    bus.playerX = 10'd0;
    pix("midframe_alien", 10'd108, 10'd52, 8'hE3);
    pix("midframe_player", 10'd300, 10'd440, 8'h1C);
    snapshot("snap1");
    pix("dead_cell0", 10'd108, 10'd52, 8'h00);
    pix("alive_cell1", 10'd140, 10'd52, 8'hE3);
    pix("player_moved", 10'd0, 10'd440, 8'h1C);
    // Syncs: new level is seen by the third enable tick that samples it; idle clocks freeze it.
    bus.hSyncIn = 1'b0;
    bus.vSyncIn = 1'b0;
    tick(10'd700, 10'd0);
    chk("hs_t1", {15'h0, bus.hSync}, 16'h1);
    idle(5);
    tick(10'd700, 10'd0);
    chk("hs_t2", {15'h0, bus.hSync}, 16'h1);
    idle(5);
    chk("hs_hold_hi", {15'h0, bus.hSync}, 16'h1);
    tick(10'd700, 10'd0);
    chk("hs_t3", {15'h0, bus.hSync}, 16'h0);
    chk("vs_t3", {15'h0, bus.vSync}, 16'h0);
    idle(5);
    chk("hs_hold_lo", {15'h0, bus.hSync}, 16'h0);
    // Reset mid-frame: outputs clear asynchronously; snapshot state is gone until the next frameDone.
    pix("pre_rst", 10'd140, 10'd52, 8'hE3);
    idle(1);
    chk("rgb_frozen", {8'h0, bus.rgb}, 16'h00E3);
    bus.vPos = 10'd200;
    #2 reset = 1'b0;
    #1;
    chk("midrst_rgb", {8'h0, bus.rgb}, 16'h0);
    chk("midrst_hSync", {15'h0, bus.hSync}, 16'h1);
    chk("midrst_vSync", {15'h0, bus.vSync}, 16'h1);
    bus.hSyncIn = 1'b1;
    bus.vSyncIn = 1'b1;
    idle(2);
    reset = 1'b1;
    pix("postrst_alien", 10'd140, 10'd52, 8'h00);
    pix("postrst_player", 10'd0, 10'd440, 8'h00);
    snapshot("snap2");
    pix("resnap_alien", 10'd140, 10'd52, 8'hE3);
    // Grid running off the right edge is clipped, never wrapped onto the left side.
    set_game(10'd300, 10'd620, 10'd50, 32'hFFFF_FFFF, 10'd0, 10'd0, 1'b0);
    snapshot("snap3");
    pix("edge_in", 10'd628, 10'd52, 8'hE3);
    pix("edge_last", 10'd639, 10'd52, 8'hE3);
    pix("edge_clip", 10'd640, 10'd52, 8'h00);
    pix("no_wrap0", 10'd0, 10'd52, 8'h00);
    pix("no_wrap4", 10'd4, 10'd52, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
